// File: rtl/fsk_modulator_if.sv
// Byte handshake and modulator status bundle between a byte source and fsk_modulator.
interface fsk_modulator_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       bit_out;
  logic       fsk_out;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, bit_out, fsk_out
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, bit_out, fsk_out
  );
endinterface

// File: rtl/fsk_modulator.sv
// Continuous-phase binary FSK modulator: UART-framed bytes key an NCO between
// mark and space tuning words; the accumulator MSB is the RF square wave.
module fsk_modulator #(
  parameter int unsigned         PHASE_W   = 32,
  parameter int unsigned         BAUD_DIV  = 1354,
  parameter logic [PHASE_W-1:0]  FTW_MARK  = PHASE_W'(33038210),
  parameter logic [PHASE_W-1:0]  FTW_SPACE = PHASE_W'(36342031)
) (
  input  logic          clki,
  input  logic          rst_n,
  input  logic          lock,
  fsk_modulator_if.slave tx
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         shift, shift_n;
  logic [1:0]         lock_sync;
  logic               lock_s;
  logic               ready_q, busy_q, bit_q, fsk_q;
  logic               ready_n, busy_n, bit_n;
  logic [PHASE_W-1:0] phase;
  logic               accept;

  assign lock_s = lock_sync[1];
  assign accept = tx.tx_valid & ready_q;

  assign tx.tx_ready = ready_q;
  assign tx.tx_busy  = busy_q;
  assign tx.bit_out  = bit_q;
  assign tx.fsk_out  = fsk_q;

  // State register
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Framing next-state; status outputs are looked ahead from the next state so
  // they can be registered yet still track the state they describe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    if (!lock_s) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_n = START;
            cnt_n   = '0;
            idx_n   = '0;
            shift_n = tx.tx_data;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            shift_n = {1'b0, shift[7:1]};
            if (idx == 3'd7) state_n = STOP;
            else             idx_n   = idx + 3'd1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            idx_n = '0;
            if (accept) begin
              state_n = START;
              shift_n = tx.tx_data;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    ready_n = lock_sync[0] && ((state_n == IDLE) || ((state_n == STOP) && (cnt_n == CNT_LAST)));
    busy_n  = lock_sync[0] && (state_n != IDLE);
    bit_n   = 1'b1;
    if (lock_sync[0]) begin
      case (state_n)
        START:   bit_n = 1'b0;
        DATA:    bit_n = shift_n[0];
        default: bit_n = 1'b1;
      endcase
    end
  end

  // Datapath, synchroniser and registered outputs
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      lock_sync <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      bit_q     <= 1'b1;
      phase     <= '0;
      fsk_q     <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      lock_sync <= {lock_sync[0], lock};
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      bit_q     <= bit_n;
      // Phase is never cleared on symbol changes, only while unlocked.
      phase     <= lock_s ? (phase + (bit_q ? FTW_MARK : FTW_SPACE)) : '0;
      fsk_q     <= lock_s & phase[PHASE_W-1];
    end
  end

endmodule

// File: tb/tb_fsk_modulator.sv
// Directed bench for fsk_modulator: fast-baud instance for framing/phase and a
// default-parameter instance for carrier frequency.
module tb_fsk_modulator;

  localparam logic [31:0] MARK  = 32'd33038210;
  localparam logic [31:0] SPACE = 32'd36342031;

  logic clk = 1'b0;
  logic rst_n;
  logic lock;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] exp_phase;
  logic        exp_fsk;
  logic        prev_fsk;
  int          edges;

  fsk_modulator_if bus ();
  fsk_modulator_if bus2 ();

  fsk_modulator #(.PHASE_W(32), .BAUD_DIV(4), .FTW_MARK(MARK), .FTW_SPACE(SPACE)) dut (
    .clki(clk), .rst_n(rst_n), .lock(lock), .tx(bus)
  );

  fsk_modulator dut2 (
    .clki(clk), .rst_n(rst_n), .lock(lock), .tx(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of the fast instance against the bench's symbol and NCO model.
  task automatic step(input logic eb, input logic erdy, input logic ebusy, input string tag);
    @(negedge clk);
    check({tag, "_bit"},   64'(bus.bit_out),  64'(eb));
    check({tag, "_ready"}, 64'(bus.tx_ready), 64'(erdy));
    check({tag, "_busy"},  64'(bus.tx_busy),  64'(ebusy));
    check({tag, "_phase"}, 64'(dut.phase),    64'(exp_phase));
    check({tag, "_fsk"},   64'(bus.fsk_out),  64'(exp_fsk));
    exp_fsk   = exp_phase[31];
    exp_phase = exp_phase + (eb ? MARK : SPACE);
    if (!prev_fsk && bus.fsk_out) edges++;
    prev_fsk = bus.fsk_out;
  endtask

  task automatic lock_up(input string tag);
    lock = 1'b1;
    @(negedge clk);
    check({tag, "_ready_lat1"}, 64'(bus.tx_ready), 64'(0));
    check({tag, "_phase_lat1"}, 64'(dut.phase),    64'(0));
    exp_phase = '0;
    exp_fsk   = 1'b0;
    prev_fsk  = 1'b0;
    step(1'b1, 1'b1, 1'b0, tag);
  endtask

  // Caller has already presented the byte at an idle/last-stop sample.
  task automatic frame(input logic [7:0] b, input bit chain, input logic [7:0] nb, input string tag);
    logic eb;
    int   k;
    for (int i = 0; i < 40; i++) begin
      k  = i / 4;
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      step(eb, (i == 39), 1'b1, tag);
      if (i == 0) begin
        if (chain) bus.tx_data  = nb;
        else       bus.tx_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] p0;
    logic        eb;
    bit          done;

    rst_n = 1'b0;
    lock  = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    exp_phase = '0;
    exp_fsk   = 1'b0;
    prev_fsk  = 1'b0;
    edges     = 0;

    repeat (3) @(negedge clk);
    check("rst_fsk",   64'(bus.fsk_out),  64'(0));
    check("rst_bit",   64'(bus.bit_out),  64'(1));
    check("rst_ready", 64'(bus.tx_ready), 64'(0));
    check("rst_busy",  64'(bus.tx_busy),  64'(0));
    check("rst_phase", 64'(dut.phase),    64'(0));
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("nolock_ready", 64'(bus.tx_ready), 64'(0));
    check("nolock_fsk",   64'(bus.fsk_out),  64'(0));
    check("nolock_phase", 64'(dut.phase),    64'(0));

    lock_up("bringup");
    edges = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, "idle_mark");
    check("idle_mark_edges", 64'(edges), 64'(2));

    // Single frame 0xA5
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    frame(8'hA5, 1'b0, 8'h00, "a5");
    step(1'b1, 1'b1, 1'b0, "a5_after");
    step(1'b1, 1'b1, 1'b0, "a5_after2");

    // Back-to-back 0x00 then 0xFF with valid held high
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    frame(8'h00, 1'b1, 8'hFF, "b2b0");
    frame(8'hFF, 1'b0, 8'h00, "b2b1");
    step(1'b1, 1'b1, 1'b0, "b2b_after");

    // Abort 0x3C during DATA bit 3
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      eb = (i < 4) ? 1'b0 : bus.tx_data[(i/4)-1];
      if (i < 4) eb = 1'b0;
      step((i < 4) ? 1'b0 : ((8'h3C >> ((i/4)-1)) & 8'h01) != 8'h00, 1'b0, 1'b1, "abort_pre");
      if (i == 0) bus.tx_valid = 1'b0;
    end
    lock = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy",  64'(bus.tx_busy),  64'(0));
    check("abort_ready", 64'(bus.tx_ready), 64'(0));
    check("abort_fsk",   64'(bus.fsk_out),  64'(0));
    check("abort_bit",   64'(bus.bit_out),  64'(1));
    check("abort_state", 64'(dut.state),    64'(0));
    check("abort_phase", 64'(dut.phase),    64'(0));

    bus.tx_data  = 8'hAA;
    bus.tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("nolock_ignore_busy", 64'(bus.tx_busy), 64'(0));
    bus.tx_valid = 1'b0;
    @(negedge clk);

    lock_up("relock");
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    frame(8'h55, 1'b0, 8'h00, "f55");
    step(1'b1, 1'b1, 1'b0, "f55_after");

    // Default-parameter carrier: mark frequency and exact phase advance
    @(negedge clk);
    p0 = dut2.phase;
    prev_fsk = bus2.fsk_out;
    edges = 0;
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk);
      if (!prev_fsk && bus2.fsk_out) edges++;
      prev_fsk = bus2.fsk_out;
    end
    check("mark_phase_adv", 64'(dut2.phase), 64'(32'(p0 + 32'(64'(13000) * 64'(MARK)))));
    check("mark_edges_100pm1", 64'(edges >= 99 && edges <= 101), 64'(1));

    // Space frequency inside start + data bits of 0x00
    bus2.tx_data  = 8'h00;
    bus2.tx_valid = 1'b1;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    check("slow_start_bit",  64'(bus2.bit_out), 64'(0));
    check("slow_start_busy", 64'(bus2.tx_busy), 64'(1));
    repeat (10) @(negedge clk);
    p0 = dut2.phase;
    prev_fsk = bus2.fsk_out;
    edges = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (!prev_fsk && bus2.fsk_out) edges++;
      prev_fsk = bus2.fsk_out;
    end
    check("space_phase_adv", 64'(dut2.phase), 64'(32'(p0 + 32'(64'(12000) * 64'(SPACE)))));
    check("space_edges_101_102", 64'(edges >= 101 && edges <= 102), 64'(1));
    check("space_bit", 64'(bus2.bit_out), 64'(0));

    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (!bus2.tx_busy) done = 1'b1;
    end
    check("slow_frame_end", 64'(done), 64'(1));
    check("slow_ready_after", 64'(bus2.tx_ready), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_modulator.md
Name: fsk_modulator

Overview:
- Continuous-phase binary FSK modulator clocked by the 13 MHz PLL output (PLL CLKOP drives this block's CLKI).
- Accepts bytes over a valid/ready handshake and frames each one UART-style: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Keys a phase-accumulator NCO between mark and space tuning words. The accumulator MSB is the square-wave carrier sent to the RF output pin.
- Gated by the PLL lock indication.

Parameters:
- PHASE_W, 32, phase accumulator width in bits.
- BAUD_DIV, 1354, CLKI cycles per bit (13 MHz / 9600 baud); legal range 2..65535.
- FTW_MARK, 33038210, tuning word for bit 1 (about 100 kHz at 13 MHz, 32-bit accumulator).
- FTW_SPACE, 36342031, tuning word for bit 0 (about 110 kHz).

Ports:
- CLKI  in  1  13 MHz clock from PLL CLKOP.
- RST_N  in  1  asynchronous active-low reset.
- LOCK  in  1  PLL lock; synchronised internally with a 2-flop synchroniser.
- TX_DATA  in  8  byte to transmit.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  block can accept a byte this cycle.
- TX_BUSY  out  1  a frame is in progress.
- BIT_OUT  out  1  currently keyed symbol (1 = mark).
- FSK_OUT  out  1  modulated carrier, registered accumulator MSB.

Behaviour:
- Reset (RST_N low, asynchronous):
  - phase = 0, state = IDLE, baud counter = 0, bit index = 0, lock synchroniser = 0.
  - Outputs: FSK_OUT = 0, BIT_OUT = 1, TX_READY = 0, TX_BUSY = 0.
- lock_s is the synchronised LOCK signal, 2-cycle latency.
  - While lock_s = 0: state is forced to IDLE, phase is held at 0, FSK_OUT = 0, TX_READY = 0, TX_BUSY = 0, BIT_OUT = 1.
  - LOCK falling mid-frame aborts the frame. The byte is dropped and no partial frame resumes.
- States:
  - IDLE: BIT_OUT = 1; carrier runs at mark; TX_READY = lock_s.
  - START: BIT_OUT = 0.
  - DATA: BIT_OUT = shift[0]; bit index runs 0..7.
  - STOP: BIT_OUT = 1.
- Handshake:
  - Transfer happens on the rising edge where TX_VALID & TX_READY are both 1.
  - TX_DATA is latched into the shift register and the next state is START with baud counter = 0.
  - TX_READY is also 1 in the final cycle of STOP (baud counter = BAUD_DIV-1). A transfer there goes straight to START with zero idle gap; otherwise the next state is IDLE.
  - TX_DATA and TX_VALID are ignored whenever TX_READY = 0.
- Bit timing:
  - Each of START, each DATA bit and STOP lasts exactly BAUD_DIV cycles.
  - The baud counter runs 0..BAUD_DIV-1, then wraps to 0 and advances the bit.
  - DATA shifts right on each bit advance; leaving DATA happens after bit index 7 completes.
  - A frame occupies 10*BAUD_DIV cycles.
  - TX_BUSY = 1 in START, DATA and STOP.
  - TX_READY and TX_BUSY are functions of registered state only (no combinational path from TX_VALID).
- NCO:
  - Each cycle with lock_s = 1: phase <= phase + (BIT_OUT ? FTW_MARK : FTW_SPACE), modulo 2^PHASE_W, unsigned; carry-out is discarded.
  - Phase is never reset on a symbol change, so the carrier phase is continuous.
  - The selected tuning word takes effect in the same cycle BIT_OUT changes.
  - FSK_OUT <= phase[PHASE_W-1], one cycle after the phase register.
- Simultaneous events:
  - Reset overrides everything.
  - Loss of lock overrides a handshake: a transfer in the same cycle lock_s drops is not accepted, because TX_READY is already 0.

Test Plan:
- Reset / lock bring-up, BAUD_DIV = 4: hold RST_N low, release with LOCK = 0 -> FSK_OUT = 0, TX_READY = 0, phase = 0. Raise LOCK -> TX_READY = 1 exactly 2 cycles later; FSK_OUT begins toggling at mark rate.
- Single frame, BAUD_DIV = 4, byte 0xA5: BIT_OUT sequence (4 cycles each) must be 0, 1,0,1,0,0,1,0,1, 1. TX_BUSY high for exactly 40 cycles; TX_READY low from the cycle after acceptance until the last STOP cycle.
- Back-to-back: TX_VALID held high with 0x00 then 0xFF -> the second byte is accepted in the last STOP cycle of the first. Next START begins with no idle cycle; 80 busy cycles total.
- NCO accuracy with default parameters: idle at mark for 1,300,000 cycles -> FSK_OUT rising edges = 10000 ±1. Force BIT_OUT = 0 (send 0x00, measure inside data bits) -> frequency ratio space/mark = 1.10 ±0.001.
- Phase continuity: log phase around each BIT_OUT transition -> phase[n+1] - phase[n] equals the newly selected FTW, with no discontinuity or reset.
- Abort: drop LOCK during DATA bit 3 of 0x3C -> within 3 cycles state = IDLE, TX_BUSY = 0, FSK_OUT = 0. Restore LOCK and send 0x55 -> full clean frame with no residue from 0x3C.
